// File: rtl/dcache_req_pipe.sv
// dcache_req_pipe: a two-stage, branch-killable request pipe. It takes requests
// from the LSU request queue and carries them through s1 (tag) and s2 (data/hit)
// toward the dcache.
//
// The package defines the request, micro-op and branch-update types, plus the
// encoding of the replay FSM.
//
// Ports:
//   clock, reset                  single clock; synchronous active-high reset
//   i_req_valid/i_req/o_req_ready upstream request handshake
//   i_brupdate                    branch resolve / mispredict masks
//   i_flush                       pipeline flush; kills entries that use the LDQ
//   i_s2_nack                     dcache rejects the request now in s2
//   o_s1_valid/o_s1_req           live s1 request, sent to the tag array
//   o_resp_valid/o_resp           completed s2 request
//   o_drop_valid/o_drop           nacked s2 request dropped because replay is busy
//   o_replay_busy                 replay buffer is occupied
//   o_dbg_state                   replay FSM state (debug observation)
//
// Handshake: a request moves from upstream on a cycle where both i_req_valid and
// o_req_ready are high. The pipe never stalls. The response, drop and s1 outputs
// are single-cycle valid pulses and have no ready signal.

package dcache_req_pipe_pkg;
  localparam int BR_W = 8;

  typedef struct packed {
    logic [BR_W-1:0] br_mask;
    logic            uses_ldq;
    logic            uses_stq;
    logic [5:0]      rob_idx;
  } MicroOpST;

  typedef struct packed {
    MicroOpST    uop;
    logic [39:0] addr;
    logic [63:0] data;
    logic        is_hella;
  } BoomDCacheReqInternalST;

  typedef struct packed {
    logic [BR_W-1:0] resolve_mask;
    logic [BR_W-1:0] mispredict_mask;
  } BrUpdateB1ST;

  typedef struct packed {
    BrUpdateB1ST b1;
  } BrUpdateInfoST;

  typedef enum logic [1:0] {
    RP_IDLE  = 2'd0,
    RP_WAIT  = 2'd1,
    RP_RETRY = 2'd2
  } replay_state_e;
endpackage

module dcache_req_pipe
  import dcache_req_pipe_pkg::*;
#(
  parameter int unsigned REPLAY_DELAY = 4,
  parameter type         T            = BoomDCacheReqInternalST
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_req_valid,
  input  T              i_req,
  output logic          o_req_ready,
  input  BrUpdateInfoST i_brupdate,
  input  logic          i_flush,
  input  logic          i_s2_nack,
  output logic          o_s1_valid,
  output T              o_s1_req,
  output logic          o_resp_valid,
  output T              o_resp,
  output logic          o_drop_valid,
  output T              o_drop,
  output logic          o_replay_busy,
  output replay_state_e o_dbg_state
);

  localparam int CW = (REPLAY_DELAY > 1) ? $clog2(REPLAY_DELAY) : 1;

  // Kill test applied to a request held in any stage.
  function automatic logic kill_f(input T r, input BrUpdateInfoST bu, input logic fl);
    return ((r.uop.br_mask & bu.b1.mispredict_mask) != '0) | (fl & r.uop.uses_ldq);
  endfunction

  // Clears the resolved branch bits. Applied on entry to a stage and on every
  // cycle the request stays there.
  function automatic T upd_f(input T r, input BrUpdateInfoST bu);
    T o;
    o = r;
    o.uop.br_mask = r.uop.br_mask & ~bu.b1.resolve_mask;
    return o;
  endfunction

  logic          s1_valid_q, s1_valid_d;
  logic          s2_valid_q, s2_valid_d;
  T              s1_q, s1_d;
  T              s2_q, s2_d;
  T              rp_q, rp_d;
  replay_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic rp_valid, accept, in_kill, s1_kill, s2_kill, rp_kill;
  logic s1_live, s2_live, nack_live, capture;

  // The replay buffer is full whenever the FSM is not IDLE.
  assign rp_valid  = (state_q != RP_IDLE);
  assign in_kill   = kill_f(i_req, i_brupdate, i_flush);
  assign s1_kill   = kill_f(s1_q, i_brupdate, i_flush);
  assign s2_kill   = kill_f(s2_q, i_brupdate, i_flush);
  assign rp_kill   = kill_f(rp_q, i_brupdate, i_flush);

  assign o_req_ready = !rp_valid;
  assign accept      = i_req_valid & o_req_ready;
  assign s1_live     = s1_valid_q & !s1_kill;
  assign s2_live     = s2_valid_q & !s2_kill;
  // A kill takes priority over a nack, so a killed request is never captured or dropped.
  assign nack_live   = s2_live & i_s2_nack;
  assign capture     = nack_live & !rp_valid;

  assign o_s1_valid    = s1_live;
  assign o_s1_req      = upd_f(s1_q, i_brupdate);
  assign o_resp_valid  = s2_live & !i_s2_nack;
  assign o_resp        = upd_f(s2_q, i_brupdate);
  assign o_drop_valid  = nack_live & rp_valid;
  assign o_drop        = upd_f(s2_q, i_brupdate);
  assign o_replay_busy = rp_valid;
  assign o_dbg_state   = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rp_d       = upd_f(rp_q, i_brupdate);
    s1_valid_d = accept & !in_kill;
    s1_d       = upd_f(i_req, i_brupdate);
    s2_valid_d = s1_live;
    s2_d       = upd_f(s1_q, i_brupdate);
    case (state_q)
      RP_IDLE: begin
        if (capture) begin
          state_d = RP_WAIT;
          cnt_d   = '0;
          rp_d    = upd_f(s2_q, i_brupdate);
        end
      end
      RP_WAIT: begin
        if (rp_kill) begin
          state_d = RP_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(REPLAY_DELAY - 1)) begin
          state_d = RP_RETRY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RP_RETRY: begin
        // Upstream is blocked in this state, so s1 is free for the replayed request.
        state_d = RP_IDLE;
        cnt_d   = '0;
        if (!rp_kill) begin
          s1_valid_d = 1'b1;
          s1_d       = upd_f(rp_q, i_brupdate);
        end
      end
      default: begin
        state_d = RP_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      state_q    <= RP_IDLE;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  // Payload registers are qualified by their valid bits and do not need a reset.
  always_ff @(posedge clock) begin
    s1_q <= s1_d;
    s2_q <= s2_d;
    rp_q <= rp_d;
  end

endmodule
